voice_allocator: RTL and testbench

- Schedules the bank of per-voice envelope/oscillator pipelines: accepts decoded MIDI note events and assigns each to one of NUM_VOICES voices.
- Issues single-cycle note_on/note_off pulses to the chosen Envelope instance, and reclaims voices on envelope_end.
- Steals the oldest voice when all voices are busy.
- Sits between the MIDI decoder and the voice pipelines.

---
 rtl/voice_allocator_pkg.sv | 19 +
 rtl/voice_allocator_if.sv | 13 +
 rtl/voice_allocator_slot.sv | 83 ++++++++
 rtl/voice_allocator.sv | 176 +++++++++++++++++
 tb/tb_voice_allocator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared types and widths for the voice allocator and its per-voice slots.
package voice_allocator_pkg;

  localparam int MIDI_NOTE_WIDTH     = 7;
  localparam int MIDI_VELOCITY_WIDTH = 7;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    HELD      = 2'd1,
    RELEASING = 2'd2
  } voice_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake from the MIDI decoder into the voice allocator.
interface voice_allocator_if;
  import voice_allocator_pkg::*;

  logic                           event_valid;
  logic                           event_ready;
  logic                           event_is_on;
  logic [MIDI_NOTE_WIDTH-1:0]     event_note;
  logic [MIDI_VELOCITY_WIDTH-1:0] event_velocity;

  modport master (output event_valid, event_is_on, event_note, event_velocity, input event_ready);
  modport slave  (input event_valid, event_is_on, event_note, event_velocity, output event_ready);
endinterface

// File: rtl/voice_allocator_slot.sv
// One voice's bookkeeping: state, note, velocity, steal age and (with
// VOICE_SUSTAIN_PEDAL_EN) a sustain-pending flag.
module voice_allocator_slot
  import voice_allocator_pkg::*;
#(
  parameter int AGE_WIDTH = 4
) (
  input  logic                           clock_50_000_000,
  input  logic                           reset,
  input  logic                           envelope_end,
  input  logic                           allocate,
  input  logic                           release_cmd,
`ifdef VOICE_SUSTAIN_PEDAL_EN
  input  logic                           hold_pending,
  output logic                           pending_r,
`endif
  input  logic                           age_increment,
  input  logic [MIDI_NOTE_WIDTH-1:0]     alloc_note,
  input  logic [MIDI_VELOCITY_WIDTH-1:0] alloc_velocity,
  output voice_state_t                   state_r,
  output logic [MIDI_NOTE_WIDTH-1:0]     note_r,
  output logic [MIDI_VELOCITY_WIDTH-1:0] velocity_r,
  output logic [AGE_WIDTH-1:0]           age_r
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = {AGE_WIDTH{1'b1}};

  // Voice state; allocation outranks a coincident envelope_end.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state_r <= FREE;
    end else if (allocate) begin
      state_r <= HELD;
    end else if (release_cmd && state_r == HELD) begin
      state_r <= RELEASING;
    end else if (envelope_end && state_r == RELEASING) begin
      state_r <= FREE;
    end else begin
      state_r <= state_r;
    end
  end

  // Note and velocity captured at allocation.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      note_r     <= {MIDI_NOTE_WIDTH{1'b0}};
      velocity_r <= {MIDI_VELOCITY_WIDTH{1'b0}};
    end else if (allocate) begin
      note_r     <= alloc_note;
      velocity_r <= alloc_velocity;
    end else begin
      note_r     <= note_r;
      velocity_r <= velocity_r;
    end
  end

  // Saturating age since last allocation.
  always_ff @(posedge clock_50_000_000) begin
    if (reset || allocate) begin
      age_r <= {AGE_WIDTH{1'b0}};
    end else if (envelope_end && state_r == RELEASING) begin
      age_r <= {AGE_WIDTH{1'b0}};
    end else if (age_increment && state_r != FREE && age_r != AGE_MAX) begin
      age_r <= age_r + AGE_WIDTH'(1);
    end else begin
      age_r <= age_r;
    end
  end

`ifdef VOICE_SUSTAIN_PEDAL_EN
  // Note-off deferred by the sustain pedal.
  always_ff @(posedge clock_50_000_000) begin
    if (reset || allocate || release_cmd) begin
      pending_r <= 1'b0;
    end else if (hold_pending && state_r == HELD) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end
`endif

endmodule

// File: rtl/voice_allocator.sv
// Assigns MIDI note events to voices, steals the oldest when full.
// Optional sustain pedal support behind VOICE_SUSTAIN_PEDAL_EN.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                                      clock_50_000_000,
  input  logic                                      reset,
  voice_allocator_if.slave                          event_bus,
`ifdef VOICE_SUSTAIN_PEDAL_EN
  input  logic                                      sustain_pedal,
`endif
  input  logic [NUM_VOICES-1:0]                     voice_envelope_end,
  output logic [NUM_VOICES-1:0]                     voice_note_on,
  output logic [NUM_VOICES-1:0]                     voice_note_off,
  output logic [NUM_VOICES*MIDI_NOTE_WIDTH-1:0]     voice_note,
  output logic [NUM_VOICES*MIDI_VELOCITY_WIDTH-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]                     voice_busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t                   state_r, state_next_s;
  logic                           accept_s;
  logic [IDX_W-1:0]               scan_idx_r, match_idx_r, free_idx_r, oldest_idx_r, target_s;
  logic                           match_found_r, free_found_r, ev_on_r;
  logic [AGE_WIDTH-1:0]           oldest_age_r;
  logic [MIDI_NOTE_WIDTH-1:0]     ev_note_r;
  logic [MIDI_VELOCITY_WIDTH-1:0] ev_vel_r;
  logic [NUM_VOICES-1:0]          alloc_s, release_s, age_inc_s;

  voice_state_t                   slot_state_s [NUM_VOICES];
  logic [MIDI_NOTE_WIDTH-1:0]     slot_note_s  [NUM_VOICES];
  logic [MIDI_VELOCITY_WIDTH-1:0] slot_vel_s   [NUM_VOICES];
  logic [AGE_WIDTH-1:0]           slot_age_s   [NUM_VOICES];

`ifdef VOICE_SUSTAIN_PEDAL_EN
  logic [NUM_VOICES-1:0] pend_s, pending_s;
  logic                  pedal_prev_r, pedal_fall_s;

  // Previous pedal level for falling-edge detection.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) pedal_prev_r <= 1'b0;
    else       pedal_prev_r <= sustain_pedal;
  end
  assign pedal_fall_s = pedal_prev_r & ~sustain_pedal;
`endif

  assign accept_s              = (state_r == IDLE) && event_bus.event_valid;
  assign event_bus.event_ready = (state_r == IDLE);

  // FSM state register.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (event_bus.event_valid) state_next_s = SCAN; else state_next_s = IDLE;
      SCAN:    if (scan_idx_r == LAST_IDX) state_next_s = ISSUE; else state_next_s = SCAN;
      ISSUE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Event latch and one-voice-per-cycle scan for match / free / oldest.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      ev_on_r       <= 1'b0;
      ev_note_r     <= {MIDI_NOTE_WIDTH{1'b0}};
      ev_vel_r      <= {MIDI_VELOCITY_WIDTH{1'b0}};
      scan_idx_r    <= {IDX_W{1'b0}};
      match_found_r <= 1'b0;
      match_idx_r   <= {IDX_W{1'b0}};
      free_found_r  <= 1'b0;
      free_idx_r    <= {IDX_W{1'b0}};
      oldest_idx_r  <= {IDX_W{1'b0}};
      oldest_age_r  <= {AGE_WIDTH{1'b0}};
    end else if (accept_s) begin
      // Velocity-0 note-on is a note-off by MIDI convention.
      ev_on_r       <= event_bus.event_is_on && (event_bus.event_velocity != 7'd0);
      ev_note_r     <= event_bus.event_note;
      ev_vel_r      <= event_bus.event_velocity;
      scan_idx_r    <= {IDX_W{1'b0}};
      match_found_r <= 1'b0;
      free_found_r  <= 1'b0;
      oldest_idx_r  <= {IDX_W{1'b0}};
      oldest_age_r  <= {AGE_WIDTH{1'b0}};
    end else if (state_r == SCAN) begin
      scan_idx_r <= scan_idx_r + IDX_W'(1);
      if (!match_found_r && slot_state_s[scan_idx_r] != FREE && slot_note_s[scan_idx_r] == ev_note_r) begin
        match_found_r <= 1'b1;
        match_idx_r   <= scan_idx_r;
      end
      if (!free_found_r && slot_state_s[scan_idx_r] == FREE) begin
        free_found_r <= 1'b1;
        free_idx_r   <= scan_idx_r;
      end
      if (slot_age_s[scan_idx_r] > oldest_age_r) begin
        oldest_age_r <= slot_age_s[scan_idx_r];
        oldest_idx_r <= scan_idx_r;
      end
    end
  end

  // Per-voice commands for the ISSUE cycle (and pedal release).
  always_comb begin
    alloc_s   = {NUM_VOICES{1'b0}};
    release_s = {NUM_VOICES{1'b0}};
    age_inc_s = {NUM_VOICES{1'b0}};
`ifdef VOICE_SUSTAIN_PEDAL_EN
    pend_s    = {NUM_VOICES{1'b0}};
`endif
    if (match_found_r)     target_s = match_idx_r;
    else if (free_found_r) target_s = free_idx_r;
    else                   target_s = oldest_idx_r;
    if (state_r == ISSUE && ev_on_r) begin
      alloc_s[target_s] = 1'b1;
      age_inc_s         = ~alloc_s;
    end else if (state_r == ISSUE && match_found_r && slot_state_s[match_idx_r] == HELD) begin
`ifdef VOICE_SUSTAIN_PEDAL_EN
      if (sustain_pedal) pend_s[match_idx_r] = 1'b1;
      else               release_s[match_idx_r] = 1'b1;
`else
      release_s[match_idx_r] = 1'b1;
`endif
    end else begin
      age_inc_s = {NUM_VOICES{1'b0}};
    end
`ifdef VOICE_SUSTAIN_PEDAL_EN
    release_s = release_s | (pending_s & {NUM_VOICES{pedal_fall_s}});
`endif
  end

  // Registered note_on / note_off pulses; a retrigger suppresses note_off.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      voice_note_on  <= {NUM_VOICES{1'b0}};
      voice_note_off <= {NUM_VOICES{1'b0}};
    end else begin
      voice_note_on  <= alloc_s;
      voice_note_off <= release_s & ~alloc_s;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_allocator_slot #(.AGE_WIDTH(AGE_WIDTH)) u_slot (
      .clock_50_000_000 (clock_50_000_000),
      .reset            (reset),
      .envelope_end     (voice_envelope_end[i]),
      .allocate         (alloc_s[i]),
      .release_cmd      (release_s[i]),
`ifdef VOICE_SUSTAIN_PEDAL_EN
      .hold_pending     (pend_s[i]),
      .pending_r        (pending_s[i]),
`endif
      .age_increment    (age_inc_s[i]),
      .alloc_note       (ev_note_r),
      .alloc_velocity   (ev_vel_r),
      .state_r          (slot_state_s[i]),
      .note_r           (slot_note_s[i]),
      .velocity_r       (slot_vel_s[i]),
      .age_r            (slot_age_s[i])
    );
    assign voice_note[i*MIDI_NOTE_WIDTH +: MIDI_NOTE_WIDTH]             = slot_note_s[i];
    assign voice_velocity[i*MIDI_VELOCITY_WIDTH +: MIDI_VELOCITY_WIDTH] = slot_vel_s[i];
    assign voice_busy[i]                                                = (slot_state_s[i] != FREE);
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with four voices; the pedal scenario
// runs only when VOICE_SUSTAIN_PEDAL_EN is defined.
module tb_voice_allocator;
  localparam int NV = 4;

  logic          clock_50_000_000 = 1'b0;
  logic          reset = 1'b1;
  logic [NV-1:0] voice_envelope_end = '0;
  logic [NV-1:0] voice_note_on, voice_note_off, voice_busy;
  logic [NV*7-1:0] voice_note, voice_velocity;
`ifdef VOICE_SUSTAIN_PEDAL_EN
  logic          sustain_pedal = 1'b0;
`endif

  int checks = 0;
  int passed = 0;
  logic [NV-1:0] on_q, off_q, acc_q;

  voice_allocator_if bus ();

  voice_allocator #(.NUM_VOICES(NV), .AGE_WIDTH(4)) dut (
    .clock_50_000_000   (clock_50_000_000),
    .reset              (reset),
    .event_bus          (bus.slave),
`ifdef VOICE_SUSTAIN_PEDAL_EN
    .sustain_pedal      (sustain_pedal),
`endif
    .voice_envelope_end (voice_envelope_end),
    .voice_note_on      (voice_note_on),
    .voice_note_off     (voice_note_off),
    .voice_note         (voice_note),
    .voice_velocity     (voice_velocity),
    .voice_busy         (voice_busy)
  );

  always #10 clock_50_000_000 = ~clock_50_000_000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clock_50_000_000);
    reset = 1'b1;
    voice_envelope_end = '0;
    bus.event_valid = 1'b0;
    repeat (2) @(posedge clock_50_000_000);
    @(negedge clock_50_000_000);
    reset = 1'b0;
  endtask

  // Offer one event, optionally pulse envelope_end during ISSUE, capture pulses.
  task automatic send(input logic is_on, input logic [6:0] n, input logic [6:0] v,
                      input logic [NV-1:0] end_mask);
    @(negedge clock_50_000_000);
    chk("ready_before", bus.event_ready, 1);
    bus.event_valid = 1'b1;
    bus.event_is_on = is_on;
    bus.event_note = n;
    bus.event_velocity = v;
    @(posedge clock_50_000_000);
    #1 bus.event_valid = 1'b0;
    repeat (NV) @(posedge clock_50_000_000);
    #1;
    chk("ready_in_issue", bus.event_ready, 0);
    voice_envelope_end = end_mask;
    @(posedge clock_50_000_000);
    #1;
    voice_envelope_end = '0;
    on_q = voice_note_on;
    off_q = voice_note_off;
    chk("ready_after", bus.event_ready, 1);
  endtask

  initial begin
    bus.event_valid = 1'b0;
    bus.event_is_on = 1'b0;
    bus.event_note = 7'd0;
    bus.event_velocity = 7'd0;
    do_reset();
    #1;
    chk("rst_ready", bus.event_ready, 1);
    chk("rst_busy", voice_busy, 0);
    chk("rst_on", voice_note_on, 0);
    chk("rst_off", voice_note_off, 0);
    chk("rst_note", voice_note, 0);

    // First allocation lands on voice 0.
    send(1'b1, 7'd60, 7'd100, '0);
    chk("on60_pulse", on_q, 4'b0001);
    chk("on60_off", off_q, 4'b0000);
    chk("on60_note", voice_note[6:0], 60);
    chk("on60_vel", voice_velocity[6:0], 100);
    chk("on60_busy", voice_busy, 4'b0001);
    @(posedge clock_50_000_000);
    #1 chk("on60_pulse_end", voice_note_on, 0);

    // Fill remaining voices, then steal the oldest (voice 0, age 3).
    send(1'b1, 7'd62, 7'd80, '0);
    chk("on62_pulse", on_q, 4'b0010);
    send(1'b1, 7'd64, 7'd80, '0);
    chk("on64_pulse", on_q, 4'b0100);
    send(1'b1, 7'd65, 7'd80, '0);
    chk("on65_pulse", on_q, 4'b1000);
    chk("full_busy", voice_busy, 4'b1111);
    send(1'b1, 7'd67, 7'd70, '0);
    chk("steal_pulse", on_q, 4'b0001);
    chk("steal_note", voice_note[6:0], 67);
    chk("steal_n1", voice_note[13:7], 62);
    // Next oldest is voice 1 (age 3 after the steal).
    send(1'b1, 7'd69, 7'd70, '0);
    chk("steal2_pulse", on_q, 4'b0010);
    chk("steal2_note", voice_note[13:7], 69);

    // Note-off then envelope_end frees voice 0 for reuse.
    do_reset();
    send(1'b1, 7'd60, 7'd100, '0);
    send(1'b0, 7'd60, 7'd0, '0);
    chk("off60_pulse", off_q, 4'b0001);
    chk("off60_on", on_q, 4'b0000);
    chk("rel_busy", voice_busy, 4'b0001);
    @(negedge clock_50_000_000);
    voice_envelope_end = 4'b0001;
    @(posedge clock_50_000_000);
    #1 voice_envelope_end = '0;
    chk("end_busy", voice_busy, 4'b0000);
    send(1'b1, 7'd72, 7'd50, '0);
    chk("on72_pulse", on_q, 4'b0001);
    chk("on72_note", voice_note[6:0], 72);

    // Unmatched note-off is silently consumed.
    send(1'b0, 7'd50, 7'd10, '0);
    chk("off50_on", on_q, 4'b0000);
    chk("off50_off", off_q, 4'b0000);
    chk("off50_busy", voice_busy, 4'b0001);

    // Retrigger while HELD, envelope_end on HELD ignored, vel-0 note-off.
    do_reset();
    send(1'b1, 7'd60, 7'd100, '0);
    send(1'b1, 7'd60, 7'd90, '0);
    chk("retrig_pulse", on_q, 4'b0001);
    chk("retrig_busy", voice_busy, 4'b0001);
    chk("retrig_vel", voice_velocity[6:0], 90);
    @(negedge clock_50_000_000);
    voice_envelope_end = 4'b0001;
    @(posedge clock_50_000_000);
    #1 voice_envelope_end = '0;
    chk("end_on_held", voice_busy, 4'b0001);
    send(1'b1, 7'd60, 7'd0, '0);
    chk("vel0_off", off_q, 4'b0001);
    chk("vel0_on", on_q, 4'b0000);

    // Retrigger of a RELEASING voice coinciding with its envelope_end: note_on wins.
    send(1'b1, 7'd60, 7'd40, 4'b0001);
    chk("race_pulse", on_q, 4'b0001);
    chk("race_busy", voice_busy, 4'b0001);
    send(1'b0, 7'd60, 7'd0, '0);
    chk("race_off", off_q, 4'b0001);

    // Reset mid-scan discards the event.
    do_reset();
    @(negedge clock_50_000_000);
    bus.event_valid = 1'b1;
    bus.event_is_on = 1'b1;
    bus.event_note = 7'd61;
    bus.event_velocity = 7'd33;
    @(posedge clock_50_000_000);
    #1 bus.event_valid = 1'b0;
    repeat (2) @(posedge clock_50_000_000);
    do_reset();
    acc_q = '0;
    for (int i = 0; i < NV + 3; i++) begin
      @(posedge clock_50_000_000);
      #1 acc_q = acc_q | voice_note_on | voice_note_off;
    end
    chk("midscan_pulses", acc_q, 0);
    chk("midscan_busy", voice_busy, 0);

`ifdef VOICE_SUSTAIN_PEDAL_EN
    // Pedal defers note-offs; release together on the falling edge.
    send(1'b1, 7'd60, 7'd100, '0);
    send(1'b1, 7'd62, 7'd100, '0);
    @(negedge clock_50_000_000);
    sustain_pedal = 1'b1;
    send(1'b0, 7'd60, 7'd0, '0);
    chk("ped_off0", off_q, 4'b0000);
    send(1'b0, 7'd62, 7'd0, '0);
    chk("ped_off1", off_q, 4'b0000);
    @(negedge clock_50_000_000);
    sustain_pedal = 1'b0;
    @(posedge clock_50_000_000);
    #1 chk("ped_fall", voice_note_off, 4'b0011);
    @(posedge clock_50_000_000);
    #1 chk("ped_fall_end", voice_note_off, 4'b0000);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
